// File: rtl/uart_cmd_responder.sv
// Host UART command engine: decodes write/read/burst frames from the byte
// receiver, runs 8-bit register bus cycles and returns data/acks as bytes.
module uart_cmd_responder #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RX_TIMEOUT = 100000,
  parameter logic [7:0]  ACK_BYTE   = 8'h06
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output logic       err_overrun,
  output logic       err_timeout
);

  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned LW = 2;
  localparam int unsigned CW = 9;

  localparam logic [2:0] OP_WR     = 3'd1;
  localparam logic [2:0] OP_RD     = 3'd2;
  localparam logic [2:0] OP_INCR   = 3'd3;
  localparam logic [2:0] OP_STREAM = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_LEN,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_WAIT_RD,
    S_SEND
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op, w_op_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [LW-1:0]   r_lat, w_lat_nxt;
  logic [TW-1:0]   r_tmo, w_tmo_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_tx_valid, w_tx_valid_nxt;
  logic [7:0]      r_bus_addr, w_bus_addr_nxt;
  logic [7:0]      r_bus_wdata, w_bus_wdata_nxt;
  logic            r_bus_we, w_bus_we_nxt;
  logic            r_bus_re, w_bus_re_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_err_overrun, w_err_overrun_nxt;
  logic            r_err_timeout, w_err_timeout_nxt;
  logic            w_expire;
  logic            w_rd_done;
  logic            w_in_bus;

  assign w_expire  = (r_tmo == TW'(RX_TIMEOUT - 1));
  assign w_rd_done = (r_lat == LW'(RD_LATENCY - 1));
  assign w_in_bus  = (r_state == S_BUS_WR) || (r_state == S_BUS_RD) ||
                     (r_state == S_WAIT_RD) || (r_state == S_SEND);

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_cnt         <= '0;
      r_lat         <= '0;
      r_tmo         <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_bus_we      <= 1'b0;
      r_bus_re      <= 1'b0;
      r_busy        <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_cnt         <= w_cnt_nxt;
      r_lat         <= w_lat_nxt;
      r_tmo         <= w_tmo_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_valid    <= w_tx_valid_nxt;
      r_bus_addr    <= w_bus_addr_nxt;
      r_bus_wdata   <= w_bus_wdata_nxt;
      r_bus_we      <= w_bus_we_nxt;
      r_bus_re      <= w_bus_re_nxt;
      r_busy        <= w_busy_nxt;
      r_err_overrun <= w_err_overrun_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  // Next-state decode; strobes are set on entry so they are high for exactly
  // the one cycle spent in BUS_WR / BUS_RD.
  always_comb begin
    w_state_nxt       = r_state;
    w_op_nxt          = r_op;
    w_cnt_nxt         = r_cnt;
    w_lat_nxt         = r_lat;
    w_tmo_nxt         = r_tmo;
    w_tx_data_nxt     = r_tx_data;
    w_tx_valid_nxt    = r_tx_valid;
    w_bus_addr_nxt    = r_bus_addr;
    w_bus_wdata_nxt   = r_bus_wdata;
    w_bus_we_nxt      = 1'b0;
    w_bus_re_nxt      = 1'b0;
    w_err_overrun_nxt = r_err_overrun;
    w_err_timeout_nxt = r_err_timeout;

    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data >= 8'h01) && (rx_data <= 8'h04)) begin
          w_op_nxt    = rx_data[2:0];
          w_tmo_nxt   = '0;
          w_state_nxt = S_GET_ADDR;
        end
      end

      S_GET_ADDR: begin
        if (rx_valid) begin
          w_tmo_nxt      = '0;
          w_bus_addr_nxt = rx_data;
          if (r_op == OP_WR) begin
            w_state_nxt = S_GET_DATA;
          end else if (r_op == OP_RD) begin
            w_cnt_nxt    = CW'(1);
            w_bus_re_nxt = 1'b1;
            w_state_nxt  = S_BUS_RD;
          end else begin
            w_state_nxt = S_GET_LEN;
          end
        end else if (w_expire) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end

      S_GET_LEN: begin
        if (rx_valid) begin
          w_tmo_nxt    = '0;
          w_cnt_nxt    = CW'(rx_data) + CW'(1);
          w_bus_re_nxt = 1'b1;
          w_state_nxt  = S_BUS_RD;
        end else if (w_expire) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end

      S_GET_DATA: begin
        if (rx_valid) begin
          w_tmo_nxt       = '0;
          w_bus_wdata_nxt = rx_data;
          w_cnt_nxt       = CW'(1);
          w_bus_we_nxt    = 1'b1;
          w_state_nxt     = S_BUS_WR;
        end else if (w_expire) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end

      S_BUS_WR: begin
        w_tx_data_nxt  = ACK_BYTE;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = S_SEND;
      end

      S_BUS_RD: begin
        w_lat_nxt   = '0;
        w_state_nxt = S_WAIT_RD;
      end

      S_WAIT_RD: begin
        if (w_rd_done) begin
          w_tx_data_nxt  = bus_rdata;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end else begin
          w_lat_nxt = r_lat + LW'(1);
        end
      end

      S_SEND: begin
        // Next read is only issued once this byte has been accepted.
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_cnt_nxt      = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_bus_re_nxt = 1'b1;
            if (r_op == OP_INCR) begin
              w_bus_addr_nxt = r_bus_addr + 8'd1;
            end
            w_state_nxt = S_BUS_RD;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Bytes arriving while a response is being produced are dropped.
    if (rx_valid && w_in_bus) begin
      w_err_overrun_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_we      = r_bus_we;
  assign bus_re      = r_bus_re;
  assign busy        = r_busy;
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;

  // OP_STREAM is the fall-through case (address held); named for readability.
  logic w_unused_op;
  assign w_unused_op = (OP_STREAM == 3'd4);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a fixed-latency register bus model.
module tb_uart_cmd_responder;

  localparam int unsigned L   = 2;
  localparam int unsigned TMO = 300;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       busy;
  logic       err_overrun;
  logic       err_timeout;

  uart_cmd_responder #(
    .RD_LATENCY(L),
    .RX_TIMEOUT(TMO),
    .ACK_BYTE  (8'h06)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .busy       (busy),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Register bus model: data valid only in the L-th cycle after the strobe.
  logic [7:0] pipe [0:L-1];
  logic       fifo_mode = 1'b0;
  int         fifo_cnt  = 0;
  assign bus_rdata = pipe[L-1];

  always @(posedge CLK) begin
    if (bus_re) begin
      if (fifo_mode) begin
        pipe[0]  <= 8'(fifo_cnt);
        fifo_cnt <= fifo_cnt + 1;
      end else begin
        pipe[0] <= (bus_addr == 8'h80) ? 8'h5A : bus_addr;
      end
    end else begin
      pipe[0] <= 8'hEE;
    end
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  // Monitor: logs strobes and transfers and flags protocol violations.
  logic [7:0] re_log [0:511];
  logic [7:0] tx_log [0:511];
  int         n_re = 0, n_we = 0, n_tx = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00;
  int         hold_err = 0, drop_err = 0, ooo_err = 0;
  logic       prev_stall = 1'b0, prev_xfer = 1'b0, outstanding = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge CLK) begin
    if (RESET) begin
      outstanding = 1'b0;
      prev_stall  = 1'b0;
      prev_xfer   = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || tx_data != prev_data)) hold_err++;
      if (prev_xfer && tx_valid) drop_err++;
      if (bus_re) begin
        if (outstanding) ooo_err++;
        outstanding = 1'b1;
        re_log[n_re] = bus_addr;
        n_re++;
      end
      if (bus_we) begin
        we_addr = bus_addr;
        we_data = bus_wdata;
        n_we++;
      end
      if (tx_valid && tx_ready) begin
        tx_log[n_tx] = tx_data;
        n_tx++;
        outstanding = 1'b0;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_xfer  = tx_valid && tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int b_re, b_we, b_tx, f_base, bad;

  initial begin
    RESET    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick(3);

    // Reset values
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_txvalid", 32'(tx_valid), 32'd0);
    check("rst_bus",     {16'd0, bus_addr, bus_wdata}, 32'd0);
    check("rst_strobes", {29'd0, bus_we, bus_re, tx_data != 8'h00}, 32'd0);
    RESET = 1'b0;
    tick(2);

    // Write 0x90 <- 0x0A
    b_re = n_re; b_we = n_we; b_tx = n_tx;
    send_byte(8'h01); send_byte(8'h90); send_byte(8'h0A);
    wait_idle("wr_done", 20);
    check("wr_we_cnt", 32'(n_we - b_we), 32'd1);
    check("wr_addr",   32'(we_addr),     32'h90);
    check("wr_data",   32'(we_data),     32'h0A);
    check("wr_no_re",  32'(n_re - b_re), 32'd0);
    check("wr_tx_cnt", 32'(n_tx - b_tx), 32'd1);
    check("wr_ack",    32'(tx_log[b_tx]), 32'h06);

    // Single read at 0x80, model returns 0x5A
    b_re = n_re; b_tx = n_tx;
    send_byte(8'h02); send_byte(8'h80);
    wait_idle("rd_done", 20);
    check("rd_re_cnt", 32'(n_re - b_re), 32'd1);
    check("rd_addr",   32'(re_log[b_re]), 32'h80);
    check("rd_data",   32'(tx_log[b_tx]), 32'h5A);

    // Incrementing burst across the 0xFF wrap, with a 50-cycle tx stall
    b_re = n_re; b_tx = n_tx;
    send_byte(8'h03); send_byte(8'hFE); send_byte(8'h02);
    bad = 0;
    while ((n_tx - b_tx) < 1 && bad < 50) begin tick(1); bad++; end
    check("incr_first", 32'(n_tx - b_tx), 32'd1);
    tx_ready = 1'b0;
    tick(50);
    check("incr_stall_re",    32'(n_re - b_re), 32'd2);
    check("incr_stall_valid", 32'(tx_valid),    32'd1);
    check("incr_stall_data",  32'(tx_data),     32'hFF);
    tx_ready = 1'b1;
    wait_idle("incr_done", 50);
    check("incr_re_cnt", 32'(n_re - b_re), 32'd3);
    check("incr_addrs",  {8'd0, re_log[b_re], re_log[b_re+1], re_log[b_re+2]}, 32'h00FEFF00);
    check("incr_tx",     {8'd0, tx_log[b_tx], tx_log[b_tx+1], tx_log[b_tx+2]}, 32'h00FEFF00);

    // Stream burst of 200 reads from a FIFO port, with one overrun byte
    fifo_mode = 1'b1;
    f_base = fifo_cnt;
    b_re = n_re; b_tx = n_tx;
    send_byte(8'h04); send_byte(8'h00); send_byte(8'hC7);
    bad = 0;
    while ((n_tx - b_tx) < 100 && bad < 1000) begin tick(1); bad++; end
    check("strm_ovr_pre", 32'(err_overrun), 32'd0);
    send_byte(8'hAA);
    tick(1);
    check("strm_ovr", 32'(err_overrun), 32'd1);
    wait_idle("strm_done", 2000);
    fifo_mode = 1'b0;
    check("strm_re_cnt", 32'(n_re - b_re), 32'd200);
    check("strm_tx_cnt", 32'(n_tx - b_tx), 32'd200);
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (re_log[b_re+k] != 8'h00) bad++;
      if (tx_log[b_tx+k] != 8'(f_base + k)) bad++;
    end
    check("strm_content", 32'(bad), 32'd0);
    check("hold_err", 32'(hold_err), 32'd0);
    check("drop_err", 32'(drop_err), 32'd0);
    check("ooo_err",  32'(ooo_err),  32'd0);

    // Timeout after a lone opcode byte
    b_re = n_re; b_we = n_we; b_tx = n_tx;
    send_byte(8'h02);
    tick(TMO - 2);
    check("tmo_busy_early", {30'd0, busy, err_timeout}, 32'b10);
    tick(2);
    check("tmo_busy", 32'(busy),        32'd0);
    check("tmo_err",  32'(err_timeout), 32'd1);
    check("tmo_no_strobe", 32'((n_re - b_re) + (n_we - b_we) + (n_tx - b_tx)), 32'd0);
    send_byte(8'h02); send_byte(8'h14);
    wait_idle("tmo_rd_done", 20);
    check("tmo_rd_data", 32'(tx_log[b_tx]), 32'h14);

    // Unknown opcode is ignored
    b_tx = n_tx;
    send_byte(8'h55);
    tick(5);
    check("unk_busy", 32'(busy), 32'd0);
    check("unk_tx",   32'(n_tx - b_tx), 32'd0);

    // Asynchronous reset while a burst read is outstanding
    b_re = n_re;
    send_byte(8'h03); send_byte(8'h10); send_byte(8'h05);
    bad = 0;
    while ((n_re - b_re) < 3 && bad < 100) begin tick(1); bad++; end
    check("rst_mid_reached", 32'(n_re - b_re), 32'd3);
    #1 RESET = 1'b1;
    #1;
    check("arst_busy",  32'(busy),    32'd0);
    check("arst_data",  {16'd0, tx_data, bus_addr}, 32'd0);
    check("arst_flags", {28'd0, err_overrun, err_timeout, tx_valid, bus_re}, 32'd0);
    b_re = n_re;
    tick(3);
    RESET = 1'b0;
    tick(5);
    check("arst_no_re", 32'(n_re - b_re), 32'd0);
    b_tx = n_tx;
    send_byte(8'h02); send_byte(8'h33);
    wait_idle("post_rst_done", 20);
    check("post_rst_data", 32'(tx_log[b_tx]), 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
